// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: owns HI/LO, runs a fixed-latency multiply or a
// 32-cycle restoring divide, and stalls the front of the pipeline while busy.
module mdu_ctrl #(
    parameter int MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        EXE_Valid,
    input  logic [2:0]  EXE_MduOp,
    input  logic [31:0] EXE_RsData,
    input  logic [31:0] EXE_RtData,
    input  logic        EXE_Flush,
    input  logic        PipeStall,
    output logic        MDU_Stall,
    output logic        MDU_Busy,
    output logic [31:0] MDU_Hi,
    output logic [31:0] MDU_Lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [2:0]  op_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] div_q;
    logic [31:0] div_r;

    logic        in_mul_op;
    logic        in_div_op;
    logic        start;
    logic        op_signed;
    logic [31:0] rs_mag_in;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [31:0] div_d;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] next_r;
    logic [31:0] next_q;
    logic [31:0] fix_q;
    logic [31:0] fix_r;

    always_comb begin
        in_mul_op = (EXE_MduOp == OP_MULT) || (EXE_MduOp == OP_MULTU);
        in_div_op = (EXE_MduOp == OP_DIV)  || (EXE_MduOp == OP_DIVU);
        start     = EXE_Valid && !EXE_Flush && (in_mul_op || in_div_op);
        rs_mag_in = ((EXE_MduOp == OP_DIV) && EXE_RsData[31]) ? -EXE_RsData : EXE_RsData;

        op_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

        // Sign- or zero-extend to 64 bits so one truncated multiply serves both flavours.
        ext_a   = op_signed ? {{32{rs_q[31]}}, rs_q} : {32'b0, rs_q};
        ext_b   = op_signed ? {{32{rt_q[31]}}, rt_q} : {32'b0, rt_q};
        product = ext_a * ext_b;

        div_d   = (op_signed && rt_q[31]) ? -rt_q : rt_q;
        shifted = {div_r, div_q[31]};
        fits    = shifted >= {1'b0, div_d};
        next_r  = fits ? 32'(shifted - {1'b0, div_d}) : shifted[31:0];
        next_q  = {div_q[30:0], fits};
        fix_q   = (op_signed && (rs_q[31] ^ rt_q[31])) ? -next_q : next_q;
        fix_r   = (op_signed && rs_q[31]) ? -next_r : next_r;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            count <= '0;
            op_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            div_q <= '0;
            div_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= EXE_MduOp;
                        rs_q <= EXE_RsData;
                        rt_q <= EXE_RtData;
                        if (in_mul_op) begin
                            count <= 5'(MUL_LAT - 1);
                            state <= MUL;
                        end else begin
                            count <= 5'd31;
                            div_q <= rs_mag_in;
                            div_r <= '0;
                            state <= DIV;
                        end
                    end else if (EXE_Valid && !EXE_Flush) begin
                        if (EXE_MduOp == OP_MTHI) hi <= EXE_RsData;
                        if (EXE_MduOp == OP_MTLO) lo <= EXE_RsData;
                    end
                end
                MUL: begin
                    if (EXE_Flush) begin
                        state <= IDLE;
                    end else if (count == 5'd0) begin
                        hi    <= product[63:32];
                        lo    <= product[31:0];
                        state <= DONE;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                DIV: begin
                    if (EXE_Flush) begin
                        state <= IDLE;
                    end else begin
                        div_r <= next_r;
                        div_q <= next_q;
                        if (count == 5'd0) begin
                            hi    <= fix_r;
                            lo    <= fix_q;
                            state <= DONE;
                        end else begin
                            count <= count - 5'd1;
                        end
                    end
                end
                DONE: begin
                    // Hold here until the instruction leaves EXE so it is not restarted.
                    if (EXE_Flush || !PipeStall) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MDU_Busy  = (state == MUL) || (state == DIV);
    assign MDU_Stall = resetn && !EXE_Flush &&
                       (((state == IDLE) && start) || (state == MUL) || (state == DIV));
    assign MDU_Hi    = hi;
    assign MDU_Lo    = lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected HI:LO pushed at issue, popped in the first DONE cycle.
module tb_mdu_ctrl;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exe_valid;
    logic [2:0]  exe_op;
    logic [31:0] exe_rs;
    logic [31:0] exe_rt;
    logic        exe_flush;
    logic        pipe_stall;
    logic        mdu_stall;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .EXE_Valid  (exe_valid),
        .EXE_MduOp  (exe_op),
        .EXE_RsData (exe_rs),
        .EXE_RtData (exe_rt),
        .EXE_Flush  (exe_flush),
        .PipeStall  (pipe_stall),
        .MDU_Stall  (mdu_stall),
        .MDU_Busy   (mdu_busy),
        .MDU_Hi     (mdu_hi),
        .MDU_Lo     (mdu_lo)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", tag, actual, expected);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb;
        logic [31:0] ma, mb, q, r;
        logic        sgn;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (op == 3'b001) return sa * sb;
        if (op == 3'b010) return {32'b0, a} * {32'b0, b};
        sgn = (op == 3'b011);
        ma  = (sgn && a[31]) ? -a : a;
        mb  = (sgn && b[31]) ? -b : b;
        if (mb == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return {r, q};
    endfunction

    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int hold);
        int stalls;
        int exp_stalls;
        logic [63:0] exp;
        exp_q.push_back(model(op, a, b));
        exp_stalls = (op <= 3'b010) ? MUL_LAT + 1 : 33;
        @(negedge clk);
        exe_valid = 1'b1;
        exe_op    = op;
        exe_rs    = a;
        exe_rt    = b;
        stalls    = 0;
        #1;
        while (mdu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        checkOutput({tag, "_stall"}, 64'(stalls), 64'(exp_stalls));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        checkOutput({tag, "_hilo"}, {mdu_hi, mdu_lo}, exp);
        if (hold > 0) begin
            pipe_stall = 1'b1;
            repeat (hold - 1) begin
                @(negedge clk);
                #1;
                checkOutput({tag, "_hold_stall"}, 64'(mdu_stall), 64'd0);
                checkOutput({tag, "_hold_busy"}, 64'(mdu_busy), 64'd0);
                checkOutput({tag, "_hold_hilo"}, {mdu_hi, mdu_lo}, exp);
            end
            @(negedge clk);
            pipe_stall = 1'b0;
        end
        exe_valid = 1'b0;
        exe_op    = 3'b000;
        @(negedge clk);
        #1;
        checkOutput({tag, "_idle_busy"}, 64'(mdu_busy), 64'd0);
    endtask

    task automatic mt_write(input logic hi_sel, input logic [31:0] value);
        @(negedge clk);
        exe_valid = 1'b1;
        exe_op    = hi_sel ? 3'b101 : 3'b110;
        exe_rs    = value;
        #1;
        checkOutput("mt_stall", 64'(mdu_stall), 64'd0);
        @(negedge clk);
        exe_valid = 1'b0;
        exe_op    = 3'b000;
        #1;
        checkOutput(hi_sel ? "mthi" : "mtlo", 64'(hi_sel ? mdu_hi : mdu_lo), 64'(value));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn     = 1'b0;
        exe_valid  = 1'b0;
        exe_op     = 3'b000;
        exe_rs     = '0;
        exe_rt     = '0;
        exe_flush  = 1'b0;
        pipe_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_hilo", {mdu_hi, mdu_lo}, 64'd0);
        checkOutput("reset_stall", 64'(mdu_stall), 64'd0);
        checkOutput("reset_busy", 64'(mdu_busy), 64'd0);
        resetn = 1'b1;

        applyStimulus("mult",   3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        checkOutput("mult_const", {mdu_hi, mdu_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        applyStimulus("multu",  3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        checkOutput("multu_const", {mdu_hi, mdu_lo}, 64'h0000_0001_FFFF_FFFE);
        applyStimulus("div",    3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 0);
        checkOutput("div_const", {mdu_hi, mdu_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus("divu",   3'b100, 32'd100, 32'd7, 0);
        checkOutput("divu_const", {mdu_hi, mdu_lo}, 64'h0000_0002_0000_000E);
        applyStimulus("divu0",  3'b100, 32'h1234_5678, 32'h0, 0);
        checkOutput("divu0_const", {mdu_hi, mdu_lo}, 64'h1234_5678_FFFF_FFFF);
        applyStimulus("divovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checkOutput("divovf_const", {mdu_hi, mdu_lo}, 64'h0000_0000_8000_0000);

        for (int i = 0; i < 8; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 2 == 0) b = -b;
            applyStimulus("rand", op, a, b, 0);
        end

        mt_write(1'b1, 32'h5);
        mt_write(1'b0, 32'h5);

        // Flush in the tenth DIV cycle must cancel without touching HI/LO.
        @(negedge clk);
        exe_valid = 1'b1;
        exe_op    = 3'b011;
        exe_rs    = 32'd1000;
        exe_rt    = 32'd3;
        repeat (10) @(negedge clk);
        #1;
        checkOutput("flush_pre_busy", 64'(mdu_busy), 64'd1);
        exe_flush = 1'b1;
        #1;
        checkOutput("flush_stall", 64'(mdu_stall), 64'd0);
        @(negedge clk);
        exe_valid = 1'b0;
        exe_flush = 1'b0;
        exe_op    = 3'b000;
        #1;
        checkOutput("flush_busy", 64'(mdu_busy), 64'd0);
        checkOutput("flush_hilo", {mdu_hi, mdu_lo}, 64'h0000_0005_0000_0005);
        repeat (40) @(negedge clk);
        #1;
        checkOutput("flush_late_hilo", {mdu_hi, mdu_lo}, 64'h0000_0005_0000_0005);

        applyStimulus("hold", 3'b001, 32'h0000_1234, 32'hFFFF_FFFE, 3);

        mt_write(1'b1, 32'hABCD);

        // Async reset in the middle of a multiply.
        @(negedge clk);
        exe_valid = 1'b1;
        exe_op    = 3'b001;
        exe_rs    = 32'd3;
        exe_rt    = 32'd4;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_pre_busy", 64'(mdu_busy), 64'd1);
        resetn = 1'b0;
        #1;
        checkOutput("rst_hilo", {mdu_hi, mdu_lo}, 64'd0);
        checkOutput("rst_stall", 64'(mdu_stall), 64'd0);
        checkOutput("rst_busy", 64'(mdu_busy), 64'd0);
        exe_valid = 1'b0;
        exe_op    = 3'b000;
        @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checkOutput("rst_after_hilo", {mdu_hi, mdu_lo}, 64'd0);
        checkOutput("rst_after_busy", 64'(mdu_busy), 64'd0);

        checkOutput("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
